vrased_rst_seq: RTL and testbench
=================================

VRASED_RST_SEQ -- requirements
Module: vrased_rst_seq

Interface
REQ-001 Parameter RST_CYCLES, default 4: number of cycles cpu_rst is held high per violation event; legal range 1..255.
REQ-002 Parameter RESET_HANDLER, default 16'h0000: PC value that proves the CPU has re-entered the reset vector.
REQ-003 Parameter PC_TIMEOUT, default 16: maximum cycles to wait for pc==RESET_HANDLER after release; legal range 1..255.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high system reset.
REQ-006 viol  input  6  per-monitor violation requests, bit order [0]=X_stack, [1]=AC, [2]=atomicity, [3]=dma_AC, [4]=dma_detect, [5]=dma_X_stack; level-sensitive, sampled each cycle.
REQ-007 pc  input  16  CPU program counter.
REQ-008 clr_cause  input  1  single-cycle pulse that clears the sticky cause register.
REQ-009 cpu_rst  output  1  registered reset request to the CPU core.
REQ-010 cause  output  6  sticky OR of all viol bits seen since the last clear.
REQ-011 viol_cnt  output  8  saturating count of violation events.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, HOLD and WAIT_PC.
REQ-014 A violation event SHALL be any cycle with viol!=0 in IDLE or WAIT_PC; it SHALL move the FSM to HOLD on the next edge.
REQ-015 In HOLD, cpu_rst SHALL be 1 and an 8-bit hold counter SHALL count from 0; the FSM SHALL leave HOLD once RST_CYCLES cycles have elapsed, giving exactly RST_CYCLES cycles of cpu_rst=1.
REQ-016 cpu_rst SHALL be driven from a register, rising exactly one cycle after the first cycle with viol!=0 (latency 1).
REQ-017 viol!=0 during HOLD SHALL restart the hold counter; that restart SHALL NOT count as a new event.
REQ-018 From HOLD the FSM SHALL enter WAIT_PC with cpu_rst=0 and a timeout counter cleared to 0.
REQ-019 In WAIT_PC, pc==RESET_HANDLER SHALL return the FSM to IDLE on the next edge.
REQ-020 In WAIT_PC, if PC_TIMEOUT cycles elapse without pc==RESET_HANDLER, the FSM SHALL re-enter HOLD; this SHALL count as a violation event.
REQ-021 Within WAIT_PC, viol!=0 SHALL take priority over pc==RESET_HANDLER in the same cycle.
REQ-022 Each cycle, cause SHALL update to (cause | viol); on clr_cause it SHALL update to viol, so bits asserted in the clear cycle are kept.
REQ-023 viol_cnt SHALL increment by 1 per violation event (REQ-014, REQ-020) and saturate at 8'hFF.
REQ-024 viol_cnt SHALL NOT be cleared by clr_cause.
REQ-025 busy SHALL be 1 in HOLD and WAIT_PC and 0 in IDLE.

Reset
REQ-026 On reset=1 at a rising edge: FSM=IDLE, cpu_rst=0, cause=0, viol_cnt=0, busy=0, all internal counters=0.
REQ-027 reset SHALL override all other inputs in the same cycle, including mid-HOLD and mid-WAIT_PC, with no residual cpu_rst pulse.

Verification
REQ-028 Single violation: viol=6'b000100 for 1 cycle, pc=0 after release -> cpu_rst high cycles 1..4, busy high, then IDLE; cause=6'b000100, viol_cnt=1.
REQ-029 Extension: viol[1] pulsed at cycle 0 and again at cycle 3 -> cpu_rst high cycles 1..7; cause=6'b000010, viol_cnt=1.
REQ-030 Timeout: one violation, pc held at 16'hE000 -> after 4 cycles high then 16 cycles low, cpu_rst reasserts; viol_cnt=2.
REQ-031 Clear race: cause=6'b000011, then clr_cause and viol=6'b100000 in the same cycle -> cause=6'b100000.
REQ-032 Saturation: 300 violation events, each released with pc=0 -> viol_cnt=8'hFF.
REQ-033 Reset mid-HOLD: reset asserted in cycle 2 of HOLD -> cpu_rst=0, cause=0, viol_cnt=0 on the next edge.

Source files
------------

// File: rtl/vrased_rst_seq_if.sv
// vrased_rst_seq_if: violation/PC inputs and reset-request/status outputs of the reset sequencer.
interface vrased_rst_seq_if;
  logic [5:0]  viol;
  logic [15:0] pc;
  logic        clr_cause;
  logic        cpu_rst;
  logic [5:0]  cause;
  logic [7:0]  viol_cnt;
  logic        busy;
  modport master (output viol, pc, clr_cause, input cpu_rst, cause, viol_cnt, busy);
  modport slave  (input viol, pc, clr_cause, output cpu_rst, cause, viol_cnt, busy);
endinterface

// File: rtl/vrased_rst_seq.sv
// vrased_rst_seq: holds the CPU in reset on monitor violations and waits for it to re-enter the reset vector.
module vrased_rst_seq #(
  parameter int          RST_CYCLES    = 4,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          PC_TIMEOUT    = 16
) (
  input logic             clk,
  input logic             reset,
  vrased_rst_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HOLD, WAIT_PC} state_t;
  localparam logic [7:0] HOLD_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0] TMO_LAST  = 8'(PC_TIMEOUT - 1);
  state_t     r_state, w_next;
  logic [7:0] r_hold, w_hold, r_tmo, w_tmo, r_cnt;
  logic [5:0] r_cause;
  logic       r_cpu_rst, w_event, w_viol;
  assign w_viol = |bus.viol;
  always_comb begin
    w_next  = r_state;
    w_hold  = r_hold;
    w_tmo   = r_tmo;
    w_event = 1'b0;
    case (r_state)
      IDLE: begin
        w_next  = w_viol ? HOLD : IDLE;
        w_hold  = w_viol ? 8'd0 : r_hold;
        w_event = w_viol;
      end
      HOLD: begin
        w_next = (!w_viol && r_hold == HOLD_LAST) ? WAIT_PC : HOLD;
        w_hold = w_viol ? 8'd0 : r_hold + 8'd1;
        w_tmo  = 8'd0;
      end
      WAIT_PC: begin
        // a new violation beats the reset-vector match in the same cycle
        w_event = w_viol || (bus.pc != RESET_HANDLER && r_tmo == TMO_LAST);
        w_next  = w_event ? HOLD : (bus.pc == RESET_HANDLER) ? IDLE : WAIT_PC;
        w_hold  = 8'd0;
        w_tmo   = r_tmo + 8'd1;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_tmo     <= '0;
      r_cnt     <= '0;
      r_cause   <= '0;
      r_cpu_rst <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_hold    <= w_hold;
      r_tmo     <= w_tmo;
      r_cnt     <= (w_event && r_cnt != 8'hFF) ? r_cnt + 8'd1 : r_cnt;
      r_cause   <= bus.clr_cause ? bus.viol : (r_cause | bus.viol);
      r_cpu_rst <= (w_next == HOLD);
    end
  end
  assign bus.cpu_rst  = r_cpu_rst;
  assign bus.cause    = r_cause;
  assign bus.viol_cnt = r_cnt;
  assign bus.busy     = (r_state != IDLE);
endmodule

// File: tb/tb_vrased_rst_seq.sv
// tb_vrased_rst_seq: directed scenarios plus random traffic checked against a countdown reference model.
module tb_vrased_rst_seq;
  localparam int RC = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  vrased_rst_seq_if bus ();
  vrased_rst_seq dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int total = 0;
  int bad = 0;
  // model: cycles of cpu_rst still owed, cycles left before the PC wait times out
  int m_hold = 0;
  int m_wait = 0;
  int m_cnt = 0;
  logic [5:0] m_cause = '0;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic bump();
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endtask
  task automatic step(input logic r, input logic [5:0] v, input logic [15:0] p, input logic c);
    reset = r;
    bus.viol = v;
    bus.pc = p;
    bus.clr_cause = c;
    if (r) begin
      m_hold = 0; m_wait = 0; m_cnt = 0; m_cause = '0;
    end else begin
      m_cause = c ? v : (m_cause | v);
      if (v != 0) begin
        if (m_hold == 0) bump();
        m_hold = RC;
        m_wait = 0;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_wait = TO;
      end else if (m_wait > 0) begin
        if (p == 16'h0000) m_wait = 0;
        else if (m_wait == 1) begin
          bump();
          m_hold = RC;
          m_wait = 0;
        end else m_wait--;
      end
    end
    @(posedge clk);
    #1;
    chk("cpu_rst", 16'(bus.cpu_rst), 16'(m_hold > 0));
    chk("busy", 16'(bus.busy), 16'(m_hold > 0 || m_wait > 0));
    chk("cause", 16'(bus.cause), 16'(m_cause));
    chk("viol_cnt", 16'(bus.viol_cnt), 16'(m_cnt));
  endtask
  initial begin
    bus.viol = '0;
    bus.pc = '0;
    bus.clr_cause = 1'b0;
    step(1, 0, 0, 0);
    chk("reset_cnt", 16'(bus.viol_cnt), 16'h0);
    // single violation, released at pc=0
    step(0, 6'b000100, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
    chk("single_cause", 16'(bus.cause), 16'h04);
    chk("single_cnt", 16'(bus.viol_cnt), 16'h1);
    chk("single_idle", 16'(bus.busy), 16'h0);
    // extension of the hold by a second request at cycle 3
    step(1, 0, 0, 0);
    step(0, 6'b000010, 16'hE000, 0);
    step(0, 0, 16'hE000, 0);
    step(0, 0, 16'hE000, 0);
    step(0, 6'b000010, 16'hE000, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 16'hE000, 0);
    chk("ext_rst_c7", 16'(bus.cpu_rst), 16'h1);
    step(0, 0, 16'hE000, 0);
    chk("ext_rst_c8", 16'(bus.cpu_rst), 16'h0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("ext_cause", 16'(bus.cause), 16'h02);
    chk("ext_cnt", 16'(bus.viol_cnt), 16'h1);
    // timeout re-entry with pc stuck away from the handler
    step(1, 0, 0, 0);
    step(0, 6'b000001, 16'hE000, 0);
    for (int i = 0; i < 19; i++) step(0, 0, 16'hE000, 0);
    chk("tmo_low_c20", 16'(bus.cpu_rst), 16'h0);
    step(0, 0, 16'hE000, 0);
    chk("tmo_rst_c21", 16'(bus.cpu_rst), 16'h1);
    chk("tmo_cnt", 16'(bus.viol_cnt), 16'h2);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    // clear racing with a fresh violation
    step(1, 0, 0, 0);
    step(0, 6'b000011, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    step(0, 6'b100000, 0, 1);
    chk("clr_race", 16'(bus.cause), 16'h20);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    // saturation
    step(1, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      step(0, 6'b000001, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    end
    chk("sat_cnt", 16'(bus.viol_cnt), 16'hFF);
    // reset in the middle of HOLD
    step(1, 0, 0, 0);
    step(0, 6'b001000, 16'hE000, 0);
    step(0, 0, 16'hE000, 0);
    step(1, 0, 16'hE000, 0);
    chk("midhold_rst", 16'(bus.cpu_rst), 16'h0);
    chk("midhold_cause", 16'(bus.cause), 16'h0);
    chk("midhold_cnt", 16'(bus.viol_cnt), 16'h0);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(99) == 0),
           ($urandom_range(7) == 0) ? 6'($urandom) : 6'd0,
           ($urandom_range(2) == 0) ? 16'h0000 : 16'($urandom),
           ($urandom_range(15) == 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
